commit_trace_queue: RTL and testbench

//  Parametrised commit tracer for the difftest harness, on the writeback side of the core.

---
 rtl/commit_trace_queue.sv | 199 +++++++++++++++++++
 tb/tb_commit_trace_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_queue.sv
// Commit tracer for the difftest harness: pairs each retiring instruction with the
// next commit's pc and queues completed records for a valid/ready consumer.
module commit_trace_queue #(
  parameter int PC_WD      = 64,
  parameter int INST_WD    = 32,
  parameter int RF_ADDR_WD = 5,
  parameter int RF_DATA_WD = 64,
  parameter int DEPTH      = 8,
  parameter int STOP_DLY   = 4,
  parameter int DROP_WD    = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ws_valid,
  input  logic [PC_WD-1:0]             wb_pc,
  input  logic [INST_WD-1:0]           wb_inst,
  input  logic                         wb_rf_wen,
  input  logic [RF_ADDR_WD-1:0]        wb_rf_wnum,
  input  logic [RF_DATA_WD-1:0]        wb_rf_wdata,
  input  logic                         stop,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic [PC_WD-1:0]             rec_pc,
  output logic [PC_WD-1:0]             rec_dnpc,
  output logic [INST_WD-1:0]           rec_inst,
  output logic                         rec_wen,
  output logic [RF_ADDR_WD-1:0]        rec_wnum,
  output logic [RF_DATA_WD-1:0]        rec_wdata,
  output logic                         rec_halt,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [DROP_WD-1:0]           drop_cnt,
  output logic                         drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_WD-1:0]      pc;
    logic [INST_WD-1:0]    inst;
    logic                  wen;
    logic [RF_ADDR_WD-1:0] wnum;
    logic [RF_DATA_WD-1:0] wdata;
  } pend_t;

  typedef struct packed {
    logic [PC_WD-1:0]      pc;
    logic [PC_WD-1:0]      dnpc;
    logic [INST_WD-1:0]    inst;
    logic                  wen;
    logic [RF_ADDR_WD-1:0] wnum;
    logic [RF_DATA_WD-1:0] wdata;
    logic                  halt;
  } rec_t;

  rec_t                mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  pend_t               pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                halted_q, halted_d;
  logic [STOP_DLY-1:0] stop_sr_q, stop_sr_d;
  logic                overflow_q, overflow_d;
  logic [DROP_WD-1:0]  drop_cnt_q, drop_cnt_d;

  logic  stop_dly;
  logic  do_halt;
  logic  do_commit;
  logic  push;
  logic  pop;
  logic  wr_en;
  logic  drop;
  logic  empty;
  logic  full;
  rec_t  push_rec;
  rec_t  head;

  // Wrap bit differs with equal index bits only when every slot is occupied.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rec_valid = !empty;
  assign pop       = rec_valid && rec_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    stop_sr_d    = stop_sr_q;
    stop_sr_d[0] = stop;
    for (int i = 1; i < STOP_DLY; i++) begin
      stop_sr_d[i] = stop_sr_q[i-1];
    end

    stop_dly  = stop_sr_q[STOP_DLY-1];
    do_halt   = stop_dly && !halted_q;
    do_commit = ws_valid && !halted_q && !stop_dly;

    push     = 1'b0;
    push_rec = '0;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    halted_d = halted_q;

    if (do_halt) begin
      // Final record: the held instruction falls through to pc+4, or a bare halt marker.
      push          = 1'b1;
      push_rec.halt = 1'b1;
      if (pend_v_q) begin
        push_rec.pc    = pend_q.pc;
        push_rec.dnpc  = pend_q.pc + PC_WD'(4);
        push_rec.inst  = pend_q.inst;
        push_rec.wen   = pend_q.wen;
        push_rec.wnum  = pend_q.wnum;
        push_rec.wdata = pend_q.wdata;
      end
      pend_v_d = 1'b0;
      halted_d = 1'b1;
    end else if (do_commit) begin
      if (pend_v_q) begin
        push           = 1'b1;
        push_rec.pc    = pend_q.pc;
        push_rec.dnpc  = wb_pc;
        push_rec.inst  = pend_q.inst;
        push_rec.wen   = pend_q.wen;
        push_rec.wnum  = pend_q.wnum;
        push_rec.wdata = pend_q.wdata;
      end
      pend_d.pc    = wb_pc;
      pend_d.inst  = wb_inst;
      pend_d.wen   = wb_rf_wen;
      pend_d.wnum  = wb_rf_wnum;
      pend_d.wdata = wb_rf_wdata;
      pend_v_d     = 1'b1;
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;

    overflow_d = overflow_q || drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + DROP_WD'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      halted_q   <= 1'b0;
      stop_sr_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge value of its sources regardless of statement order.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      halted_q   <= halted_d;
      stop_sr_q  <= stop_sr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live,
  // and the outputs are masked while empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
    end
  end

  assign rec_pc    = rec_valid ? head.pc    : '0;
  assign rec_dnpc  = rec_valid ? head.dnpc  : '0;
  assign rec_inst  = rec_valid ? head.inst  : '0;
  assign rec_wen   = rec_valid ? head.wen   : 1'b0;
  assign rec_wnum  = rec_valid ? head.wnum  : '0;
  assign rec_wdata = rec_valid ? head.wdata : '0;
  assign rec_halt  = rec_valid ? head.halt  : 1'b0;

  assign count    = CW'(wr_ptr_q - rd_ptr_q);
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign drained  = halted_q && empty && !pend_v_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Scoreboard bench for commit_trace_queue: directed commit/stop sequences push
// expected records; a negedge monitor compares every record the DUT hands over.
module tb_commit_trace_queue;

  localparam int PC_WD      = 64;
  localparam int INST_WD    = 32;
  localparam int RF_ADDR_WD = 5;
  localparam int RF_DATA_WD = 64;
  localparam int DEPTH      = 8;
  localparam int STOP_DLY   = 4;
  localparam int DROP_WD    = 16;
  localparam int CW         = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  ws_valid;
  logic [PC_WD-1:0]      wb_pc;
  logic [INST_WD-1:0]    wb_inst;
  logic                  wb_rf_wen;
  logic [RF_ADDR_WD-1:0] wb_rf_wnum;
  logic [RF_DATA_WD-1:0] wb_rf_wdata;
  logic                  stop;
  logic                  rec_valid;
  logic                  rec_ready;
  logic [PC_WD-1:0]      rec_pc;
  logic [PC_WD-1:0]      rec_dnpc;
  logic [INST_WD-1:0]    rec_inst;
  logic                  rec_wen;
  logic [RF_ADDR_WD-1:0] rec_wnum;
  logic [RF_DATA_WD-1:0] rec_wdata;
  logic                  rec_halt;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic [DROP_WD-1:0]    drop_cnt;
  logic                  drained;

  commit_trace_queue #(
    .PC_WD(PC_WD), .INST_WD(INST_WD), .RF_ADDR_WD(RF_ADDR_WD), .RF_DATA_WD(RF_DATA_WD),
    .DEPTH(DEPTH), .STOP_DLY(STOP_DLY), .DROP_WD(DROP_WD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ws_valid(ws_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_rf_wen(wb_rf_wen),
    .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata), .stop(stop),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pc(rec_pc), .rec_dnpc(rec_dnpc),
    .rec_inst(rec_inst), .rec_wen(rec_wen), .rec_wnum(rec_wnum), .rec_wdata(rec_wdata),
    .rec_halt(rec_halt), .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_WD-1:0]      pc;
    logic [PC_WD-1:0]      dnpc;
    logic [INST_WD-1:0]    inst;
    logic                  wen;
    logic [RF_ADDR_WD-1:0] wnum;
    logic [RF_DATA_WD-1:0] wdata;
    logic                  halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Payload fields are derived from the pc so each record is distinguishable.
  function automatic logic [INST_WD-1:0] f_inst(input logic [PC_WD-1:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction
  function automatic logic f_wen(input logic [PC_WD-1:0] pc);
    return pc[3];
  endfunction
  function automatic logic [RF_ADDR_WD-1:0] f_wnum(input logic [PC_WD-1:0] pc);
    return pc[8:4];
  endfunction
  function automatic logic [RF_DATA_WD-1:0] f_wdata(input logic [PC_WD-1:0] pc);
    return {pc[31:0], ~pc[31:0]};
  endfunction

  task automatic exp_push(input logic [PC_WD-1:0] pc, input logic [PC_WD-1:0] dnpc,
                          input logic halt);
    exp_t e;
    e.pc = pc; e.dnpc = dnpc; e.inst = f_inst(pc); e.wen = f_wen(pc);
    e.wnum = f_wnum(pc); e.wdata = f_wdata(pc); e.halt = halt;
    exp_q.push_back(e);
  endtask

  task automatic exp_push_zero_halt();
    exp_t e;
    e.pc = '0; e.dnpc = '0; e.inst = '0; e.wen = 1'b0; e.wnum = '0; e.wdata = '0; e.halt = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [PC_WD-1:0] pc);
    ws_valid    = 1'b1;
    wb_pc       = pc;
    wb_inst     = f_inst(pc);
    wb_rf_wen   = f_wen(pc);
    wb_rf_wnum  = f_wnum(pc);
    wb_rf_wdata = f_wdata(pc);
    step();
    ws_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // Monitor: a handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_record", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc",   rec_pc,   e.pc);
        check("sb_dnpc", rec_dnpc, e.dnpc);
        check("sb_halt", rec_halt, e.halt);
        check("sb_payload", {rec_inst, rec_wen, rec_wnum, rec_wdata},
                            {e.inst, e.wen, e.wnum, e.wdata});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  logic [PC_WD-1:0] pcs [11];
  int drain_cycles;

  initial begin
    resetn = 1'b0; ws_valid = 1'b0; wb_pc = '0; wb_inst = '0; wb_rf_wen = 1'b0;
    wb_rf_wnum = '0; wb_rf_wdata = '0; stop = 1'b0; rec_ready = 1'b0;
    for (int i = 0; i < 11; i++) pcs[i] = 64'h2000 + 64'(8 * i);
    #12;
    check("rst_rec_valid", rec_valid, 0);
    check("rst_count",     count,     0);
    check("rst_overflow",  overflow,  0);
    check("rst_drop_cnt",  drop_cnt,  0);
    check("rst_drained",   drained,   0);
    check("rst_rec_pc",    rec_pc,    0);
    resetn = 1'b1;
    step();

    // Pairing: three commits yield two records, third stays pending.
    rec_ready = 1'b1;
    exp_push(64'h8000_0000, 64'h8000_0004, 1'b0);
    exp_push(64'h8000_0004, 64'h8000_0010, 1'b0);
    commit(64'h8000_0000);
    check("t1_first_no_record", rec_valid, 0);
    commit(64'h8000_0004);
    commit(64'h8000_0010);
    step(); step(); step();
    check("t1_count_zero", count, 0);
    check("t1_not_drained", drained, 0);

    // Delayed stop: halt record lands STOP_DLY+1 edges after stop is sampled.
    exp_push(64'h8000_0010, 64'h8000_0014, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step(); step();
    check("t2_no_halt_yet", rec_valid, 0);
    step();
    check("t2_halt_valid", rec_valid, 1);
    check("t2_halt_flag",  rec_halt,  1);
    step(); step(); step();
    check("t2_drained", drained, 1);
    check("t2_count",   count,   0);

    // Overflow: ten commits with the consumer stalled; the 9th record is dropped.
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_push(pcs[i], pcs[i+1], 1'b0);
    for (int i = 0; i < 10; i++) commit(pcs[i]);
    check("t3_count_full", count,    8);
    check("t3_overflow",   overflow, 1);
    check("t3_drop_cnt",   drop_cnt, 1);
    check("t3_head_pc",    rec_pc,   pcs[0]);

    // Full with simultaneous push and pop: occupancy held, no extra drop.
    exp_push(pcs[9], pcs[10], 1'b0);
    rec_ready = 1'b1;
    commit(pcs[10]);
    rec_ready = 1'b0;
    check("t4_count_held", count,    8);
    check("t4_drop_cnt",   drop_cnt, 1);
    check("t4_head_adv",   rec_pc,   pcs[1]);

    rec_ready = 1'b1;
    drain_cycles = 0;
    while (count != 0 && drain_cycles < 40) begin
      step();
      drain_cycles++;
    end
    check("t4_drain_done",      count,    0);
    check("t4_overflow_sticky", overflow, 1);

    // Reset in the middle of a burst discards queued and pending records.
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) commit(64'h3000 + 64'(16 * i));
    check("t6_count_five", count, 5);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_count",     count,     0);
    check("t6_rst_valid",     rec_valid, 0);
    check("t6_rst_overflow",  overflow,  0);
    check("t6_rst_drop_cnt",  drop_cnt,  0);
    step();
    resetn = 1'b1;
    step();
    rec_ready = 1'b1;
    commit(64'h4000);
    step(); step();
    check("t6_first_no_record", count, 0);
    check("t6_first_no_valid",  rec_valid, 0);
    exp_push(64'h4000, 64'h4010, 1'b0);
    commit(64'h4010);
    step(); step();
    check("t6_second_drained_out", count, 0);

    // stop_d coincides with a commit: that commit is swallowed.
    exp_push(64'h4010, 64'h4014, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step(); step();
    commit(64'h100);
    check("t5_halt_pc",   rec_pc,   64'h4010);
    check("t5_halt_flag", rec_halt, 1);
    commit(64'h200);
    commit(64'h204);
    step(); step(); step();
    check("t5_post_halt_count", count,   0);
    check("t5_drained",         drained, 1);

    // Halt with nothing pending yields an all-zero record flagged halt.
    do_reset();
    rec_ready = 1'b1;
    exp_push_zero_halt();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step(); step(); step();
    check("t7_zero_halt_flag", rec_halt, 1);
    check("t7_zero_halt_pc",   rec_pc,   0);
    step(); step();
    check("t7_drained", drained, 1);

    check("sb_all_consumed", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
